pc_ras_unit: RTL
================

PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, the pcaddr value after reset.
REQ-002 SHALL have parameter WORD_W, default 32, the address width; legal range 16..64.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, the return-address-stack entry count; a power of two, 2..16.
REQ-004 SHALL have ports: CLK  in  1  clock; RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: pc_en  in  1  advance enable; redirect  in  1  flush/exception redirect; redirect_pc  in  WORD_W  redirect target.
REQ-006 SHALL have ports: branch_taken  in  1; branch_pc  in  WORD_W  branch base; bimm  in  WORD_W  sign-extended word offset.
REQ-007 SHALL have ports: jr  in  1  register jump; jraddr  in  WORD_W; ret  in  1  jr is a return (jr $31); jump  in  1; call  in  1  jump is link (JAL); jimm  in  WORD_W-6.
REQ-008 SHALL have ports: pcaddr  out  WORD_W; nxt_pc  out  WORD_W  pcaddr+4; ras_top  out  WORD_W; ras_empty  out  1; ras_full  out  1; ras_ovf  out  1  sticky overflow.

Function
REQ-009 SHALL drive nxt_pc = pcaddr + 4 combinationally, modulo 2^WORD_W.
REQ-010 SHALL load pcaddr with the selected target on the rising CLK edge where pc_en=1; pc_en=0 holds pcaddr and freezes the RAS.
REQ-011 SHALL select the target by priority: redirect > branch_taken > jr > jump > nxt_pc.
REQ-012 SHALL compute the branch target as branch_pc + (bimm << 2), truncated to WORD_W.
REQ-013 SHALL compute the jump target as {pcaddr[WORD_W-1:WORD_W-4], jimm, 2'b00}.
REQ-014 SHALL use ras_top as the jr target when ret=1 and ras_empty=0, and jraddr otherwise.
REQ-015 SHALL push nxt_pc onto the RAS when call=1 and jump wins the priority selection.
REQ-016 SHALL pop the RAS when ret=1 and jr wins the priority selection with ras_empty=0.
REQ-017 SHALL NOT change the RAS when pc_en=0 or when a higher-priority source overrides the call or return.
REQ-018 SHALL treat a push at full as circular: overwrite the oldest entry, keep the count at RAS_DEPTH, and set ras_ovf.
REQ-019 SHALL treat a pop at empty as a no-op; the count never underflows.
REQ-020 SHALL hold ras_ovf set until RST.
REQ-021 SHALL assert ras_empty when count=0 and ras_full when count=RAS_DEPTH; ras_top SHALL read 0 when empty.

Reset
REQ-022 SHALL set, on CLK with RST=1: pcaddr=PC_INIT, RAS count=0, all RAS entries=0, ras_ovf=0, ras_empty=1, ras_full=0.
REQ-023 SHALL give RST priority over pc_en and every control input in the same cycle.

Configuration
REQ-024 SHALL compile the RAS only when macro PC_RAS_EN is defined.
REQ-025 SHALL, without PC_RAS_EN, always use jraddr for jr, ignore call and ret, tie ras_top=0, ras_empty=1, ras_full=0, ras_ovf=0, and instantiate no RAS storage.

Structure
REQ-026 SHALL take word_t and the opcode-independent address constants (PC increment 4, word shift 2) from cpu_types_pkg.
REQ-027 SHALL implement the stack in one sub-module, ras_stack (push, pop, top, count, ovf), parametrised by WORD_W and RAS_DEPTH.

Verification
REQ-028 SHALL cover reset: RST=1 for 2 cycles, then pc_en=1 for 3 cycles -> pcaddr 0x0, 0x4, 0x8, 0xC; ras_empty=1.
REQ-029 SHALL cover priority: redirect=1 (redirect_pc=0x8000), branch_taken=1, jr=1 in the same cycle -> pcaddr=0x8000 and no RAS change.
REQ-030 SHALL cover call/return: at pcaddr=0x100 assert jump+call with jimm=0x40 -> pcaddr=0x100, ras_top=0x104; next cycle assert jr+ret with jraddr=0xDEAD0 -> pcaddr=0x104, ras_empty=1.
REQ-031 SHALL cover overflow: 5 calls with RAS_DEPTH=4, pushing 0x14, 0x24, 0x34, 0x44, 0x54 -> ras_full=1, ras_ovf=1; 4 returns yield 0x54, 0x44, 0x34, 0x24, then ras_empty=1.
REQ-032 SHALL cover empty pop and stall: jr+ret at empty with jraddr=0x200 -> pcaddr=0x200; pc_en=0 while call=1 -> pcaddr and RAS unchanged.
REQ-033 SHALL cover the branch boundary: branch_pc=0xFFFF_FFF0, bimm=0x8 -> pcaddr=0x0000_0010 (wrap); bimm=0xFFFF_FFFF -> branch_pc-4.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU word type, address-step constants and PC source selection helper.
// Used by pc_ras_unit; the return-address stack is built only when PC_RAS_EN is defined.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int PC_INCR    = 4;
    localparam int WORD_SHIFT = 2;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_REDIRECT,
        SRC_BRANCH,
        SRC_JR,
        SRC_JUMP
    } pc_src_e;

    // Fixed priority: redirect > branch > jr > jump > sequential.
    function automatic pc_src_e pick_src(input logic redirect, input logic branch_taken,
                                         input logic jr, input logic jump);
        if (redirect)          return SRC_REDIRECT;
        else if (branch_taken) return SRC_BRANCH;
        else if (jr)           return SRC_JR;
        else if (jump)         return SRC_JUMP;
        else                   return SRC_SEQ;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push at full overwrites the oldest entry and sets a
// sticky overflow flag; a pop at empty does nothing.
module ras_stack #(
    parameter int WORD_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WORD_W-1:0]            push_data,
    output logic [WORD_W-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         ovf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [WORD_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  top_idx;

    // wr_ptr names the next free slot; at full it wraps onto the oldest entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
            if (count == CNT_MAX) begin
                ovf <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (pop && (count != '0)) begin
            wr_ptr <= wr_ptr - 1'b1;
            count  <= count - 1'b1;
        end
    end

    assign top_idx = wr_ptr - 1'b1;
    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign top     = empty ? '0 : mem[top_idx];

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with prioritised next-PC selection and an optional return-address
// stack; define PC_RAS_EN to build the stack, otherwise jr always uses jraddr.
module pc_ras_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT   = 32'h0000_0000,
    parameter int    WORD_W    = 32,
    parameter int    RAS_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              pc_en,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_pc,
    input  logic [WORD_W-1:0] bimm,
    input  logic              jr,
    input  logic [WORD_W-1:0] jraddr,
    input  logic              ret,
    input  logic              jump,
    input  logic              call,
    input  logic [WORD_W-7:0] jimm,
    output logic [WORD_W-1:0] pcaddr,
    output logic [WORD_W-1:0] nxt_pc,
    output logic [WORD_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf
);

    pc_src_e           src;
    logic [WORD_W-1:0] br_tgt;
    logic [WORD_W-1:0] jmp_tgt;
    logic [WORD_W-1:0] jr_tgt;
    logic [WORD_W-1:0] pc_tgt;

    assign nxt_pc  = pcaddr + WORD_W'(PC_INCR);
    assign br_tgt  = branch_pc + (bimm << WORD_SHIFT);
    assign jmp_tgt = {pcaddr[WORD_W-1:WORD_W-4], jimm, 2'b00};
    assign src     = pick_src(redirect, branch_taken, jr, jump);

    always_comb begin
        pc_tgt = nxt_pc;
        case (src)
            SRC_REDIRECT: pc_tgt = redirect_pc;
            SRC_BRANCH:   pc_tgt = br_tgt;
            SRC_JR:       pc_tgt = jr_tgt;
            SRC_JUMP:     pc_tgt = jmp_tgt;
            default:      pc_tgt = nxt_pc;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pcaddr <= WORD_W'(PC_INIT);
        end else if (pc_en) begin
            pcaddr <= pc_tgt;
        end
    end

`ifdef PC_RAS_EN
    logic                       do_push;
    logic                       do_pop;
    logic [$clog2(RAS_DEPTH):0] unused_ras_count;

    // Stack moves only when the call/return actually steers the PC this cycle.
    assign do_push = pc_en && (src == SRC_JUMP) && call;
    assign do_pop  = pc_en && (src == SRC_JR) && ret && !ras_empty;
    assign jr_tgt  = (ret && !ras_empty) ? ras_top : jraddr;

    ras_stack #(
        .WORD_W    (WORD_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .RST       (RST),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (nxt_pc),
        .top       (ras_top),
        .count     (unused_ras_count),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_ovf)
    );
`else
    logic unused_ras_ctl;

    assign unused_ras_ctl = call ^ ret;
    assign jr_tgt         = jraddr;
    assign ras_top        = '0;
    assign ras_empty      = 1'b1;
    assign ras_full       = 1'b0;
    assign ras_ovf        = 1'b0;
`endif

endmodule
